// File: rtl/display_pkg.sv
// Shared display-pipeline constants and helpers.
//   H_LAST_DEF / V_LAST_DEF : default last x / y count including blanking
//   COLOR_W_DEF             : default RGB word width
//   BLACK                   : blanked-pixel colour
//   idx_w()                 : width of a layer index that can also encode "background"
package display_pkg;

  localparam int unsigned H_LAST_DEF  = 799;
  localparam int unsigned V_LAST_DEF  = 524;
  localparam int unsigned COLOR_W_DEF = 12;

  localparam logic [COLOR_W_DEF-1:0] BLACK = '0;

  // Index range is 0..n_layers, where n_layers encodes the background.
  function automatic int unsigned idx_w(input int unsigned n_layers);
    return $clog2(n_layers + 1);
  endfunction

endpackage

// File: rtl/coll_accum.sv
// One collision channel: detects overlap of a group-A and a group-B layer on a
// visible pixel, accumulates it over the frame and publishes at end of frame.
//   clk, reset       : clock, synchronous active-high reset
//   pixel_tick       : pixel enable
//   video_on         : visible-area flag
//   eof              : end-of-frame pixel tick (already qualified by pixel_tick)
//   act              : effective per-layer activity
//   mask_a, mask_b   : group-A / group-B layer masks for this channel
//   flag             : collision flag for the previous frame
module coll_accum
  import display_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pixel_tick,
  input  logic                  video_on,
  input  logic                  eof,
  input  logic [NUM_LAYERS-1:0] act,
  input  logic [NUM_LAYERS-1:0] mask_a,
  input  logic [NUM_LAYERS-1:0] mask_b,
  output logic                  flag
);

  logic [NUM_LAYERS-1:0] w_any;
  logic                  w_multi;
  logic                  w_hit;
  logic                  r_acc;
  logic                  r_flag;

  // At least two distinct active layers: clearing the lowest set bit leaves a bit set.
  always_comb begin
    w_any   = act & (mask_a | mask_b);
    w_multi = |(w_any & (w_any - NUM_LAYERS'(1)));
    w_hit   = (|(act & mask_a)) & (|(act & mask_b)) & w_multi & video_on & pixel_tick;
  end

  // Sticky accumulator; the final pixel's hit is folded into the published value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc  <= 1'b0;
      r_flag <= 1'b0;
    end else if (eof) begin
      r_flag <= r_acc | w_hit;
      r_acc  <= 1'b0;
    end else if (w_hit) begin
      r_acc  <= 1'b1;
    end
  end

  assign flag = r_flag;

endmodule

// File: rtl/layer_compositor.sv
// N-layer pixel compositor: picks the highest-priority enabled, active layer per
// pixel through a 1- or 2-tick output pipeline, and reports per-frame collisions.
//   clk, reset              : clock, synchronous active-high reset
//   pixel_tick, video_on    : pixel enable and visible-area flag from vga_sync
//   x, y                    : current pixel column / row
//   layer_on, layer_en      : per-layer pixel-active flags and runtime enables
//   layer_rgb, bg_rgb       : per-layer colours (layer i at [i*COLOR_W +: COLOR_W]), background
//   coll_mask_a/_b          : per-channel group masks (channel c at [c*NUM_LAYERS +: NUM_LAYERS])
//   rgb, win_idx            : composited colour and winning layer (NUM_LAYERS = background)
//   coll_flags, frame_done  : previous-frame collision flags and their update pulse
module layer_compositor
  import display_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 12,
  parameter int unsigned COLOR_W    = COLOR_W_DEF,
  parameter int unsigned NUM_COLL   = 4,
  parameter int unsigned PIPE       = 1,
  parameter int unsigned H_LAST     = H_LAST_DEF,
  parameter int unsigned V_LAST     = V_LAST_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           pixel_tick,
  input  logic                           video_on,
  input  logic [9:0]                     x,
  input  logic [9:0]                     y,
  input  logic [NUM_LAYERS-1:0]          layer_on,
  input  logic [NUM_LAYERS*COLOR_W-1:0]  layer_rgb,
  input  logic [NUM_LAYERS-1:0]          layer_en,
  input  logic [COLOR_W-1:0]             bg_rgb,
  input  logic [NUM_COLL*NUM_LAYERS-1:0] coll_mask_a,
  input  logic [NUM_COLL*NUM_LAYERS-1:0] coll_mask_b,
  output logic [COLOR_W-1:0]             rgb,
  output logic [idx_w(NUM_LAYERS)-1:0]   win_idx,
  output logic [NUM_COLL-1:0]            coll_flags,
  output logic                           frame_done
);

  localparam int unsigned IDX_W = idx_w(NUM_LAYERS);

  logic [NUM_LAYERS-1:0] w_act;
  logic [COLOR_W-1:0]    w_sel_rgb;
  logic [IDX_W-1:0]      w_sel_idx;
  logic                  w_eof;
  logic [COLOR_W-1:0]    r_s1_rgb;
  logic [IDX_W-1:0]      r_s1_idx;
  logic                  r_frame_done;

  // Priority select: scanning high to low leaves the lowest active index as winner.
  always_comb begin
    w_act     = layer_on & layer_en;
    w_sel_rgb = bg_rgb;
    w_sel_idx = IDX_W'(NUM_LAYERS);
    if (!video_on) begin
      w_sel_rgb = COLOR_W'(BLACK);
    end else begin
      for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
        if (w_act[i]) begin
          w_sel_rgb = layer_rgb[i*COLOR_W +: COLOR_W];
          w_sel_idx = IDX_W'(i);
        end
      end
    end
  end

  assign w_eof = pixel_tick && (x == 10'(H_LAST)) && (y == 10'(V_LAST));

  // First output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_rgb <= '0;
      r_s1_idx <= IDX_W'(NUM_LAYERS);
    end else if (pixel_tick) begin
      r_s1_rgb <= w_sel_rgb;
      r_s1_idx <= w_sel_idx;
    end
  end

  generate
    if (PIPE == 2) begin : g_pipe2
      logic [COLOR_W-1:0] r_s2_rgb;
      logic [IDX_W-1:0]   r_s2_idx;

      // Extra holding stage; rgb and index move together.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_s2_rgb <= '0;
          r_s2_idx <= IDX_W'(NUM_LAYERS);
        end else if (pixel_tick) begin
          r_s2_rgb <= r_s1_rgb;
          r_s2_idx <= r_s1_idx;
        end
      end

      assign rgb     = r_s2_rgb;
      assign win_idx = r_s2_idx;
    end else begin : g_pipe1
      assign rgb     = r_s1_rgb;
      assign win_idx = r_s1_idx;
    end
  endgenerate

  // One collision channel per mask pair.
  generate
    for (genvar c = 0; c < int'(NUM_COLL); c++) begin : g_coll
      coll_accum #(
        .NUM_LAYERS(NUM_LAYERS)
      ) u_coll_accum (
        .clk       (clk),
        .reset     (reset),
        .pixel_tick(pixel_tick),
        .video_on  (video_on),
        .eof       (w_eof),
        .act       (w_act),
        .mask_a    (coll_mask_a[c*NUM_LAYERS +: NUM_LAYERS]),
        .mask_b    (coll_mask_b[c*NUM_LAYERS +: NUM_LAYERS]),
        .flag      (coll_flags[c])
      );
    end
  endgenerate

  // Pulses on the clock that publishes coll_flags.
  always_ff @(posedge clk) begin
    if (reset) r_frame_done <= 1'b0;
    else       r_frame_done <= w_eof;
  end

  assign frame_done = r_frame_done;

endmodule
